// File: rtl/calc_input_sequencer.sv
// Front-end sequencer for the 4-bit calculator: gathers x, y and op from shared
// switches on ENTER presses, waits for the datapath to settle, then holds the result.
module calc_input_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] data_in_i,
  input  logic [1:0] op_in_i,
  input  logic       enter_i,
  input  logic       clear_i,
  output logic [3:0] calc_x_o,
  output logic [3:0] calc_y_o,
  output logic [1:0] calc_op_sel_o,
  input  logic [7:0] calc_result_i,
  input  logic       calc_carry_i,
  input  logic       calc_ovf_i,
  output logic [7:0] result_q_o,
  output logic       carry_q_o,
  output logic       ovf_q_o,
  output logic       valid_o,
  output logic [2:0] state_q_o
);

  // state  | meaning
  // S_X    | waiting for ENTER to latch x
  // S_Y    | waiting for ENTER to latch y
  // S_OP   | waiting for ENTER to latch op_sel and start the settle timer
  // S_EXEC | settle timer running; capture result at terminal count
  // S_DONE | result held and valid until the next ENTER
  typedef enum logic [2:0] {
    S_X    = 3'd0,
    S_Y    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] enter_sync_q, clear_sync_q;
  logic                   enter_prev_q, clear_prev_q;
  logic                   enter_p_q, clear_p_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       x_q, x_d, y_q, y_d;
  logic [1:0]       op_q, op_d;
  logic [7:0]       res_q, res_d;
  logic             carry_q, carry_d, ovf_q, ovf_d, valid_q, valid_d;

  // Pulses are registered so they arrive SYNC_STAGES+1 cycles after the raw edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enter_sync_q <= '0;
      clear_sync_q <= '0;
      enter_prev_q <= 1'b0;
      clear_prev_q <= 1'b0;
      enter_p_q    <= 1'b0;
      clear_p_q    <= 1'b0;
    end else begin
      enter_sync_q <= {enter_sync_q[SYNC_STAGES-2:0], enter_i};
      clear_sync_q <= {clear_sync_q[SYNC_STAGES-2:0], clear_i};
      enter_prev_q <= enter_sync_q[SYNC_STAGES-1];
      clear_prev_q <= clear_sync_q[SYNC_STAGES-1];
      enter_p_q    <= enter_sync_q[SYNC_STAGES-1] & ~enter_prev_q;
      clear_p_q    <= clear_sync_q[SYNC_STAGES-1] & ~clear_prev_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_X;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      op_q    <= op_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    op_d    = op_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    if (clear_p_q) begin
      // clear outranks a simultaneous enter
      state_d = S_X;
      cnt_d   = '0;
      x_d     = '0;
      y_d     = '0;
      op_d    = '0;
      res_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        S_X: if (enter_p_q) begin
          x_d     = data_in_i;
          state_d = S_Y;
        end
        S_Y: if (enter_p_q) begin
          y_d     = data_in_i;
          state_d = S_OP;
        end
        S_OP: if (enter_p_q) begin
          op_d    = op_in_i;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          state_d = S_EXEC;
        end
        S_EXEC: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            res_d   = calc_result_i;
            carry_d = calc_carry_i & ~op_q[1];
            ovf_d   = calc_ovf_i & ~op_q[1];
            valid_d = 1'b1;
            state_d = S_DONE;
          end
        end
        S_DONE: if (enter_p_q) begin
          valid_d = 1'b0;
          state_d = S_X;
        end
        default: state_d = S_X;
      endcase
    end
  end

  assign calc_x_o      = x_q;
  assign calc_y_o      = y_q;
  assign calc_op_sel_o = op_q;
  assign result_q_o    = res_q;
  assign carry_q_o     = carry_q;
  assign ovf_q_o       = ovf_q;
  assign valid_o       = valid_q;
  assign state_q_o     = state_q;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Directed bench for calc_input_sequencer; the calculator response is driven as
// per-test constants so every expected value is hand-computed.
module tb_calc_input_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] data_in = '0;
  logic [1:0] op_in = '0;
  logic       enter = 1'b0, clear = 1'b0;
  logic [7:0] calc_result = '0;
  logic       calc_carry = 1'b0, calc_ovf = 1'b0;
  logic [3:0] calc_x, calc_y;
  logic [1:0] calc_op_sel;
  logic [7:0] result_q;
  logic       carry_q, ovf_q, valid;
  logic [2:0] state_q;

  int errors = 0;
  int checks = 0;

  calc_input_sequencer #(.SYNC_STAGES(2), .SETTLE_CYCLES(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_in_i(data_in), .op_in_i(op_in),
    .enter_i(enter), .clear_i(clear),
    .calc_x_o(calc_x), .calc_y_o(calc_y), .calc_op_sel_o(calc_op_sel),
    .calc_result_i(calc_result), .calc_carry_i(calc_carry), .calc_ovf_i(calc_ovf),
    .result_q_o(result_q), .carry_q_o(carry_q), .ovf_q_o(ovf_q),
    .valid_o(valid), .state_q_o(state_q)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // raise enter at a negedge, hold 3 cycles, then allow 6 more for the pulse to act
  task automatic press(input logic [3:0] d, input logic [1:0] op);
    @(negedge clk);
    data_in = d;
    op_in   = op;
    enter   = 1'b1;
    cycles(3);
    enter = 1'b0;
    cycles(6);
  endtask

  task automatic run_op(input logic [3:0] x, input logic [3:0] y, input logic [1:0] op);
    press(x, 2'b00);
    press(y, 2'b00);
    press(4'h0, op);
  endtask

  task automatic test_reset;
    cycles(2);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
    checks++; if (state_q !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state_q); end
    checks++; if ({valid, result_q, carry_q, ovf_q} !== 11'd0) begin errors++; $display("FAIL reset_outputs got=%h want=0", {valid, result_q, carry_q, ovf_q}); end
    // drive into S_EXEC, then reset asynchronously mid-operation
    calc_result = 8'h5A;
    press(4'h9, 2'b00);
    press(4'h4, 2'b00);
    @(negedge clk);
    op_in = 2'b01;
    enter = 1'b1;
    cycles(4);
    checks++; if (state_q !== 3'd3) begin errors++; $display("FAIL reset_pre_exec got=%0d want=3", state_q); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({calc_x, calc_y, calc_op_sel, result_q, carry_q, ovf_q, valid, state_q} !== 27'd0) begin
      errors++; $display("FAIL reset_async got=%h want=0", {calc_x, calc_y, calc_op_sel, result_q, carry_q, ovf_q, valid, state_q});
    end
    enter = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycles(3);
    checks++; if (state_q !== 3'd0) begin errors++; $display("FAIL reset_release_state got=%0d want=0", state_q); end
  endtask

  task automatic test_add_latency;
    calc_result = 8'h08; calc_carry = 1'b0; calc_ovf = 1'b0;
    press(4'h3, 2'b00);
    press(4'h5, 2'b00);
    checks++; if ({calc_x, calc_y, state_q} !== {4'h3, 4'h5, 3'd2}) begin errors++; $display("FAIL add_operands got=%h want=%h", {calc_x, calc_y, state_q}, {4'h3, 4'h5, 3'd2}); end
    @(negedge clk);
    op_in = 2'b00;
    enter = 1'b1;
    // edges 1-2 synchronize, 3 emits enter_p, 4 enters S_EXEC, 6 raises valid
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 3) enter = 1'b0;
      if (k == 4) begin
        checks++; if (state_q !== 3'd3) begin errors++; $display("FAIL add_exec_state got=%0d want=3", state_q); end
      end
      if (k == 5) begin
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL add_valid_early got=%b want=0", valid); end
      end
      if (k == 6) begin
        checks++; if (valid !== 1'b1 || state_q !== 3'd4) begin errors++; $display("FAIL add_valid_on_time got=%b/%0d want=1/4", valid, state_q); end
      end
    end
    checks++; if ({result_q, carry_q, ovf_q} !== {8'h08, 1'b0, 1'b0}) begin errors++; $display("FAIL add_result got=%h want=%h", {result_q, carry_q, ovf_q}, {8'h08, 2'b00}); end
    cycles(5);
    checks++; if (valid !== 1'b1 || result_q !== 8'h08) begin errors++; $display("FAIL add_hold got=%b/%h want=1/08", valid, result_q); end
  endtask

  task automatic test_done_exit;
    press(4'hF, 2'b11);
    checks++; if (valid !== 1'b0 || state_q !== 3'd0) begin errors++; $display("FAIL done_exit got=%b/%0d want=0/0", valid, state_q); end
    checks++; if ({calc_x, calc_y, calc_op_sel} !== {4'h3, 4'h5, 2'b00}) begin errors++; $display("FAIL done_operands_kept got=%h want=%h", {calc_x, calc_y, calc_op_sel}, {4'h3, 4'h5, 2'b00}); end
  endtask

  task automatic test_overflow;
    calc_result = 8'h08; calc_carry = 1'b0; calc_ovf = 1'b1;
    run_op(4'h7, 4'h1, 2'b00);
    checks++; if ({valid, result_q, carry_q, ovf_q} !== {1'b1, 8'h08, 1'b0, 1'b1}) begin errors++; $display("FAIL ovf_result got=%h want=%h", {valid, result_q, carry_q, ovf_q}, {1'b1, 8'h08, 2'b01}); end
    press(4'h0, 2'b00);
  endtask

  task automatic test_subtract;
    calc_result = 8'h02; calc_carry = 1'b1; calc_ovf = 1'b0;
    run_op(4'h5, 4'h3, 2'b01);
    checks++; if (calc_op_sel !== 2'b01) begin errors++; $display("FAIL sub_op_sel got=%b want=01", calc_op_sel); end
    checks++; if ({valid, result_q, carry_q, ovf_q} !== {1'b1, 8'h02, 1'b1, 1'b0}) begin errors++; $display("FAIL sub_result got=%h want=%h", {valid, result_q, carry_q, ovf_q}, {1'b1, 8'h02, 2'b10}); end
    press(4'h0, 2'b00);
  endtask

  task automatic test_multiply;
    calc_result = 8'hE1; calc_carry = 1'b1; calc_ovf = 1'b1;
    run_op(4'hF, 4'hF, 2'b10);
    checks++; if (calc_op_sel !== 2'b10) begin errors++; $display("FAIL mul_op_sel got=%b want=10", calc_op_sel); end
    checks++; if ({valid, result_q, carry_q, ovf_q} !== {1'b1, 8'hE1, 1'b0, 1'b0}) begin errors++; $display("FAIL mul_result got=%h want=%h", {valid, result_q, carry_q, ovf_q}, {1'b1, 8'hE1, 2'b00}); end
    press(4'h0, 2'b00);
  endtask

  task automatic test_held_button;
    @(negedge clk);
    data_in = 4'hA;
    enter = 1'b1;
    cycles(50);
    checks++; if (state_q !== 3'd1 || calc_x !== 4'hA) begin errors++; $display("FAIL held_one_step got=%0d/%h want=1/a", state_q, calc_x); end
    enter = 1'b0;
    data_in = 4'h6;
    cycles(6);
    checks++; if (state_q !== 3'd1 || calc_x !== 4'hA) begin errors++; $display("FAIL held_release got=%0d/%h want=1/a", state_q, calc_x); end
  endtask

  task automatic test_clear;
    press(4'hC, 2'b00);
    checks++; if (state_q !== 3'd2) begin errors++; $display("FAIL clear_pre_state got=%0d want=2", state_q); end
    @(negedge clk);
    op_in = 2'b11;
    enter = 1'b1;
    clear = 1'b1;
    cycles(3);
    enter = 1'b0;
    clear = 1'b0;
    cycles(6);
    checks++; if ({state_q, calc_op_sel, valid} !== 6'd0) begin errors++; $display("FAIL clear_vs_enter got=%h want=0", {state_q, calc_op_sel, valid}); end
    checks++; if ({calc_x, calc_y} !== 8'h00) begin errors++; $display("FAIL clear_operands got=%h want=00", {calc_x, calc_y}); end
    calc_result = 8'h0B; calc_carry = 1'b1; calc_ovf = 1'b1;
    run_op(4'h6, 4'h5, 2'b00);
    checks++; if (valid !== 1'b1 || result_q !== 8'h0B) begin errors++; $display("FAIL clear_setup got=%b/%h want=1/0b", valid, result_q); end
    @(negedge clk);
    clear = 1'b1;
    cycles(3);
    clear = 1'b0;
    cycles(6);
    checks++; if ({state_q, valid, result_q, carry_q, ovf_q} !== 14'd0) begin errors++; $display("FAIL clear_in_done got=%h want=0", {state_q, valid, result_q, carry_q, ovf_q}); end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_done_exit();
    test_overflow();
    test_subtract();
    test_multiply();
    test_held_button();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
